pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch stage of the CGRA control path, directly downstream of the PC control logic.
- Consumes the clock-enable, load and increment strobes and the branch immediate.
- Holds the PC, reads a synchronous instruction memory and presents the current instruction to decode.
- Runs a start/run/done sequencer over a host-loaded program of programmable length.

Parameters:
PC_W, 12, PC and branch-immediate width
INSTR_W, 64, instruction word width
IMEM_DEPTH, 4096, instruction memory words (must equal 2**PC_W)

Ports:
axis_aclk  in  1  clock, rising edge
axis_resetn  in  1  asynchronous active-low reset
imem_wr_en  in  1  host instruction write strobe
imem_wr_addr  in  PC_W  host write address
imem_wr_data  in  INSTR_W  host write data
start  in  1  begin execution at PC 0
prog_len  in  PC_W+1  program length in words, 0..IMEM_DEPTH; sampled on start
clken_PC  in  1  PC update enable from PC control
load_PC  in  1  load branch target
incr_PC  in  1  increment PC
branch_imm  in  PC_W  absolute branch target
pc  out  PC_W  current PC
instr  out  INSTR_W  instruction at pc
instr_valid  out  1  instr corresponds to pc and execution active
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err_oob  out  1  sticky: branch target >= prog_len

Behaviour:
- Reset (async, axis_resetn=0): state=IDLE; pc=0, instr=0, instr_valid=0, busy=0, done=0, err_oob=0; latched length=0. Memory contents are not reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - imem_wr_en writes imem[imem_wr_addr] at the edge.
  - On start with prog_len>0: latch prog_len, pc<=0, instr<=imem[0], instr_valid<=1, err_oob<=0, go RUN. First valid instruction appears 1 cycle after start.
  - On start with prog_len==0: go DONE, clear err_oob, instr_valid stays 0.
  - If start and imem_wr_en occur in the same cycle, the write completes; the read returns the old data for the same address.
- RUN, next-PC computation:
  - If clken_PC=0, or clken_PC=1 with load_PC=incr_PC=0: pc_next=pc (hold).
  - If clken_PC=1 and load_PC=1: pc_next=branch_imm. Load wins when load_PC and incr_PC are both high.
  - If clken_PC=1 and incr_PC=1 and load_PC=0: pc_next=pc+1, computed at PC_W+1 bits with no wrap.
- RUN, memory read:
  - Memory is read at pc_next each cycle and registered into instr, so instr always matches pc.
  - No bubble on any advance or branch.
- RUN, end conditions:
  - Increment with pc+1 == latched length: go DONE, instr_valid<=0, pc holds its last value.
  - Load with branch_imm >= latched length: err_oob<=1, go DONE, instr_valid<=0, pc holds.
- DONE: done=1 and busy=1 for exactly one cycle, instr_valid=0, then go IDLE.
- While busy:
  - imem_wr_en is ignored and the write is dropped.
  - start is ignored.
- clken_PC, load_PC and incr_PC are ignored outside RUN.
- err_oob stays high until the next accepted start.
- Reset asserted mid-RUN: immediate return to all reset values. No done pulse.
- All outputs are registered except busy, which is decoded from the state register.

Decomposition:
- Shared package cgra_ctrl_pkg holds:
  - enum pc_state_t {IDLE, RUN, DONE}
  - constants PC_W=12 and INSTR_W=64
  - typedefs pc_t and instr_t
- One sub-module, imem_sp_ram: single-clock RAM with one write port and one synchronous read port (read-old-data on collision), inferred as BRAM.
- The FSM and next-PC logic stay in pc_fetch_unit.

Test Plan:
- Load imem[0..3]=A,B,C,D; start, prog_len=4; clken=incr=1 every cycle -> pc 0,1,2,3 with instr A,B,C,D and instr_valid=1 on cycles 1-4 after start; done pulses on cycle 5; busy falls on cycle 6.
- prog_len=8; at pc=5 assert clken+load+incr with branch_imm=2 -> next pc=2 and instr=imem[2] (load priority, no bubble).
- Hold clken=0 for 3 cycles at pc=1 -> pc and instr stable, instr_valid=1; then incr -> pc=2.
- prog_len=4; load with branch_imm=4 -> err_oob=1, one done pulse, instr_valid=0; err_oob holds until the next start.
- start with prog_len=0 -> done one cycle later, instr_valid never asserted; start with prog_len=4096 and incrementing to the end -> pc reaches 4095, then done with no wrap to 0.
- imem_wr_en during RUN -> memory unchanged; start during RUN ignored; axis_resetn low at pc=3 -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/cgra_ctrl_pkg.sv
// Shared types and constants for the CGRA control path.
package cgra_ctrl_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 64;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

endpackage

// File: rtl/imem_sp_ram.sv
// Instruction memory: one write port and one registered read port on a single clock.
// On a same-address write/read collision the read returns the old contents.
module imem_sp_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port; array contents are never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; the output register carries the reset so the fetched word reads 0 after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: start/run/done sequencer over a host-loaded program.
// The memory is addressed with next-PC so the registered instruction always matches pc.
module pc_fetch_unit
  import cgra_ctrl_pkg::*;
#(
  parameter int PC_W       = cgra_ctrl_pkg::PC_W,
  parameter int INSTR_W    = cgra_ctrl_pkg::INSTR_W,
  parameter int IMEM_DEPTH = 4096
) (
  input  logic               axis_aclk,
  input  logic               axis_resetn,
  input  logic               imem_wr_en,
  input  logic [PC_W-1:0]    imem_wr_addr,
  input  logic [INSTR_W-1:0] imem_wr_data,
  input  logic               start,
  input  logic [PC_W:0]      prog_len,
  input  logic               clken_PC,
  input  logic               load_PC,
  input  logic               incr_PC,
  input  logic [PC_W-1:0]    branch_imm,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  output logic               done,
  output logic               err_oob
);

  pc_state_t        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W:0]    len_q, len_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [PC_W:0]    pc_inc;
  logic             ram_wr_en;
  logic             ram_rd_en;

  // Increment is evaluated one bit wider so pc+1 == length is seen without wrapping.
  assign pc_inc = {1'b0, pc_q} + (PC_W+1)'(1);

  // Next-state, next-PC and memory-port control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = err_q;
    ram_wr_en = 1'b0;
    ram_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        ram_wr_en = imem_wr_en;
        if (start) begin
          err_d = 1'b0;
          if (prog_len != '0) begin
            len_d     = prog_len;
            pc_d      = '0;
            ram_rd_en = 1'b1;
            valid_d   = 1'b1;
            state_d   = RUN;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        ram_rd_en = 1'b1;
        if (clken_PC) begin
          if (load_PC) begin
            if ({1'b0, branch_imm} >= len_q) begin
              err_d   = 1'b1;
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              pc_d = branch_imm;
            end
          end else if (incr_PC) begin
            if (pc_inc == len_q) begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              pc_d = pc_inc[PC_W-1:0];
            end
          end
        end
      end
      DONE: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  imem_sp_ram #(
    .ADDR_W (PC_W),
    .DATA_W (INSTR_W),
    .DEPTH  (IMEM_DEPTH)
  ) u_imem (
    .clk_i     (axis_aclk),
    .rst_ni    (axis_resetn),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (imem_wr_addr),
    .wr_data_i (imem_wr_data),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (pc_d),
    .rd_data_o (instr)
  );

  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign done        = done_q;
  assign err_oob     = err_q;
  assign busy        = (state_q != IDLE);

endmodule
